// File: rtl/ym_clk_phase_gen.sv
// Two-phase c1/c2 enable generator with programmable half-period, slot counter and slot-0 sync.
// The divider is sampled only at the period boundary.
module ym_clk_phase_gen #(
  parameter int unsigned DIV_WIDTH  = 4,
  parameter int unsigned DIV_RESET  = 0,
  parameter int unsigned SLOTS      = 24,
  parameter int unsigned SLOT_WIDTH = 5
) (
  input  logic                  MCLK,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [DIV_WIDTH-1:0]  div,
  output logic                  c1,
  output logic                  c2,
  output logic [SLOT_WIDTH-1:0] slot,
  output logic                  sync
);

  localparam logic [SLOT_WIDTH-1:0] SlotLast = SLOT_WIDTH'(SLOTS - 1);

  logic [DIV_WIDTH:0]    pc_q, pc_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [SLOT_WIDTH-1:0] slot_q, slot_d;
  logic                  c1_q, c1_d;
  logic                  c2_q, c2_d;
  logic                  sync_q, sync_d;
  logic                  pc_last;
  logic                  pc_half;

  // P-1 = 2*div_q+1, which is div_q shifted left with a 1 appended.
  assign pc_last = (pc_q == {div_q, 1'b1});
  assign pc_half = (pc_q == {1'b0, div_q});

  always_comb begin
    pc_d   = pc_q;
    div_d  = div_q;
    slot_d = slot_q;
    c1_d   = 1'b0;
    c2_d   = 1'b0;
    sync_d = 1'b0;
    if (run) begin
      c1_d = pc_last;
      c2_d = pc_half;
      if (pc_last) begin
        pc_d   = '0;
        div_d  = div;
        slot_d = (slot_q == SlotLast) ? '0 : slot_q + 1'b1;
        sync_d = (slot_q == SlotLast);
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= '0;
      div_q  <= DIV_WIDTH'(DIV_RESET);
      slot_q <= SlotLast;
      c1_q   <= 1'b0;
      c2_q   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      div_q  <= div_d;
      slot_q <= slot_d;
      c1_q   <= c1_d;
      c2_q   <= c2_d;
      sync_q <= sync_d;
    end
  end

  assign c1   = c1_q;
  assign c2   = c2_q;
  assign slot = slot_q;
  assign sync = sync_q;

endmodule

// File: tb/tb_ym_clk_phase_gen.sv
// Directed bench for ym_clk_phase_gen: start-up, alternation, slot wrap, divider change,
// freeze/resume and asynchronous reset mid-period.
module tb_ym_clk_phase_gen;

  logic       MCLK = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] div = 4'd0;
  logic       c1;
  logic       c2;
  logic [4:0] slot;
  logic       sync;

  int total = 0;
  int bad = 0;

  always #5 MCLK = ~MCLK;

  ym_clk_phase_gen #(
    .DIV_WIDTH (4),
    .DIV_RESET (0),
    .SLOTS     (24),
    .SLOT_WIDTH(5)
  ) dut (
    .MCLK   (MCLK),
    .reset_n(reset_n),
    .run    (run),
    .div    (div),
    .c1     (c1),
    .c2     (c2),
    .slot   (slot),
    .sync   (sync)
  );

  task automatic chk(input string tag, input logic e1, input logic e2, input logic es,
                     input logic [4:0] esl);
    total++;
    assert ({c1, c2, sync, slot} === {e1, e2, es, esl}) else begin
      bad++;
      $error("FAIL %s: got c1=%b c2=%b sync=%b slot=%0d, want c1=%b c2=%b sync=%b slot=%0d",
             tag, c1, c2, sync, slot, e1, e2, es, esl);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  function automatic int nxt(input int s);
    return (s == 23) ? 0 : s + 1;
  endfunction

  // One full period starting right after a c1 (or reset release): c2 at edge d+1, c1 at edge P.
  task automatic period(input string tag, input int d, input int cur);
    int p;
    p = 2 * (d + 1);
    for (int i = 1; i <= p; i++) begin
      step();
      chk(tag, i == p, i == d + 1, (i == p) && (nxt(cur) == 0),
          5'((i == p) ? nxt(cur) : cur));
    end
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    run = 1'b1;
    div = 4'd0;
    #12;
    chk("reset", 1'b0, 1'b0, 1'b0, 5'd23);
    @(negedge MCLK);
    reset_n = 1'b1;

    // T1/T3: strict alternation, slot 0..23 then wrap, sync every 48 MCLK
    for (int k = 0; k <= 24; k++) period("t1_t3", 0, (k + 23) % 24);

    // Widest divider: div=15 gives P=32
    div = 4'd15;
    period("pre_max", 0, 0);
    div = 4'd2;
    period("div_max", 15, 1);
    period("after_max", 2, 2);

    // T2: reset with div=2 held; first period still uses DIV_RESET
    @(negedge MCLK);
    reset_n = 1'b0;
    div = 4'd2;
    #1;
    chk("t2_reset", 1'b0, 1'b0, 1'b0, 5'd23);
    @(negedge MCLK);
    reset_n = 1'b1;
    period("t2_first", 0, 23);
    period("t2", 2, 0);
    period("t2", 2, 1);

    // T4: div 2->5 at pc=2; current period stays 6, next is 12
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t4_cur", i == 6, i == 3, 1'b0, 5'((i == 6) ? 3 : 2));
      if (i == 2) div = 4'd5;
    end
    div = 4'd2;
    period("t4_next", 5, 3);

    // T5: freeze at pc=3 for 10 edges, then resume
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("t5_pre", 1'b0, i == 3, 1'b0, 5'd4);
    end
    run = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      chk("t5_frozen", 1'b0, 1'b0, 1'b0, 5'd4);
    end
    run = 1'b1;
    for (int i = 4; i <= 6; i++) begin
      step();
      chk("t5_resume", i == 6, 1'b0, 1'b0, 5'((i == 6) ? 5 : 4));
    end

    // T6: async reset between edges while c2 is high
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("t6_pre", 1'b0, i == 3, 1'b0, 5'd5);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async", 1'b0, 1'b0, 1'b0, 5'd23);
    div = 4'd0;
    step();
    chk("t6_hold", 1'b0, 1'b0, 1'b0, 5'd23);
    step();
    chk("t6_hold", 1'b0, 1'b0, 1'b0, 5'd23);
    @(negedge MCLK);
    reset_n = 1'b1;
    period("t6_restart", 0, 23);
    period("t6_restart", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
